// File: rtl/rgb_hsv_pkg.sv
// Shared constants for the RGB->HSV path: channel indices, hue sector codes and
// the (max, min) channel pair to sector mapping.
package rgb_hsv_pkg;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    localparam logic [2:0] SE_RB = 3'd0;
    localparam logic [2:0] SE_GB = 3'd1;
    localparam logic [2:0] SE_GR = 3'd2;
    localparam logic [2:0] SE_BR = 3'd3;
    localparam logic [2:0] SE_BG = 3'd4;
    localparam logic [2:0] SE_RG = 3'd5;

    function automatic logic [2:0] sector_of(input logic [1:0] max_idx,
                                             input logic [1:0] min_idx);
        logic [2:0] se;
        case ({max_idx, min_idx})
            {CH_R, CH_B}: se = SE_RB;
            {CH_G, CH_B}: se = SE_GB;
            {CH_G, CH_R}: se = SE_GR;
            {CH_B, CH_R}: se = SE_BR;
            {CH_B, CH_G}: se = SE_BG;
            {CH_R, CH_G}: se = SE_RG;
            // Unreachable from rgb_rank3; keeps every pair inside 0..5.
            default:      se = SE_RB;
        endcase
        return se;
    endfunction

endpackage

// File: rtl/rgb_rank3.sv
// Combinational ranking of three integer channels with a fixed tie-break:
// max prefers R over G over B, min prefers B over G over R.
module rgb_rank3
    import rgb_hsv_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic [CW-1:0] ch_r,
    input  logic [CW-1:0] ch_g,
    input  logic [CW-1:0] ch_b,
    output logic [1:0]    max_idx,
    output logic [1:0]    min_idx,
    output logic [1:0]    mid_idx,
    output logic          grey
);

    always_comb begin
        max_idx = CH_B;
        if (ch_r >= ch_g && ch_r >= ch_b) begin
            max_idx = CH_R;
        end else if (ch_g >= ch_b) begin
            max_idx = CH_G;
        end

        min_idx = CH_R;
        if (ch_b <= ch_g && ch_b <= ch_r) begin
            min_idx = CH_B;
        end else if (ch_g <= ch_r) begin
            min_idx = CH_G;
        end

        // Indices 0+1+2 sum to 3, and the tie-breaks guarantee max != min.
        mid_idx = 2'd3 - max_idx - min_idx;
        grey    = (ch_r == ch_g) && (ch_g == ch_b);
    end

endmodule

// File: rtl/rgb_extrema_pipe.sv
// Two-stage valid/ready pipeline that ranks R,G,B and emits max/min/range,
// the mid-minus-min term and the 6-sector hue code for the HSV divider stage.
module rgb_extrema_pipe
    import rgb_hsv_pkg::*;
#(
    parameter int unsigned CW = 8,
    parameter int unsigned FW = 18
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [CW-1:0] R,
    input  logic [CW-1:0] G,
    input  logic [CW-1:0] B,
    input  logic [FW-1:0] r,
    input  logic [FW-1:0] g,
    input  logic [FW-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sof,
    output logic [CW-1:0] MAX,
    output logic [CW-1:0] D,
    output logic [FW-1:0] max,
    output logic [FW-1:0] min,
    output logic [FW-1:0] max_min,
    output logic [FW-1:0] TOP,
    output logic          TOP_NEG,
    output logic [2:0]    RGB_SE,
    output logic          GREY
);

    logic          s1_valid, s1_sof, s1_grey;
    logic [CW-1:0] s1_ri, s1_gi, s1_bi;
    logic [FW-1:0] s1_rf, s1_gf, s1_bf;
    logic [1:0]    s1_max_idx, s1_min_idx, s1_mid_idx;
    logic [2:0]    s1_se;

    logic [1:0]    rk_max_idx, rk_min_idx, rk_mid_idx;
    logic          rk_grey;

    logic          s2_can_load, s1_load;
    logic [CW-1:0] sel_max_i, sel_min_i;
    logic [FW-1:0] sel_max_f, sel_min_f, sel_mid_f;

    rgb_rank3 #(
        .CW (CW)
    ) u_rank (
        .ch_r    (R),
        .ch_g    (G),
        .ch_b    (B),
        .max_idx (rk_max_idx),
        .min_idx (rk_min_idx),
        .mid_idx (rk_mid_idx),
        .grey    (rk_grey)
    );

    // Ready ripples back combinationally from out_ready; there is no skid buffer.
    assign s2_can_load = !out_valid || out_ready;
    assign in_ready    = !s1_valid || s2_can_load;
    assign s1_load     = in_valid && in_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid   <= 1'b0;
            s1_sof     <= 1'b0;
            s1_grey    <= 1'b0;
            s1_ri      <= '0;
            s1_gi      <= '0;
            s1_bi      <= '0;
            s1_rf      <= '0;
            s1_gf      <= '0;
            s1_bf      <= '0;
            s1_max_idx <= CH_R;
            s1_min_idx <= CH_B;
            s1_mid_idx <= CH_G;
            s1_se      <= SE_RB;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (s1_load) begin
                s1_sof     <= in_sof;
                s1_grey    <= rk_grey;
                s1_ri      <= R;
                s1_gi      <= G;
                s1_bi      <= B;
                s1_rf      <= r;
                s1_gf      <= g;
                s1_bf      <= b;
                s1_max_idx <= rk_max_idx;
                s1_min_idx <= rk_min_idx;
                s1_mid_idx <= rk_mid_idx;
                s1_se      <= sector_of(rk_max_idx, rk_min_idx);
            end
        end
    end

    always_comb begin
        case (s1_max_idx)
            CH_R:    begin sel_max_i = s1_ri; sel_max_f = s1_rf; end
            CH_G:    begin sel_max_i = s1_gi; sel_max_f = s1_gf; end
            default: begin sel_max_i = s1_bi; sel_max_f = s1_bf; end
        endcase
        case (s1_min_idx)
            CH_R:    begin sel_min_i = s1_ri; sel_min_f = s1_rf; end
            CH_G:    begin sel_min_i = s1_gi; sel_min_f = s1_gf; end
            default: begin sel_min_i = s1_bi; sel_min_f = s1_bf; end
        endcase
        case (s1_mid_idx)
            CH_R:    sel_mid_f = s1_rf;
            CH_G:    sel_mid_f = s1_gf;
            default: sel_mid_f = s1_bf;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            MAX       <= '0;
            D         <= '0;
            max       <= '0;
            min       <= '0;
            max_min   <= '0;
            TOP       <= '0;
            TOP_NEG   <= 1'b0;
            RGB_SE    <= SE_RB;
            GREY      <= 1'b0;
        end else if (s2_can_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sof <= s1_sof;
                MAX     <= sel_max_i;
                // Modulo subtraction: fixed inputs that disagree with the integer
                // ordering simply wrap.
                D       <= sel_max_i - sel_min_i;
                max     <= sel_max_f;
                min     <= sel_min_f;
                max_min <= sel_max_f - sel_min_f;
                TOP     <= sel_mid_f - sel_min_f;
                TOP_NEG <= s1_se[0];
                RGB_SE  <= s1_se;
                GREY    <= s1_grey;
            end
        end
    end

endmodule

// File: tb/tb_rgb_extrema_pipe.sv
// Directed bench for rgb_extrema_pipe: sectors, ties, backpressure, SOF, reset
// and a wider-parameter instance.
module tb_rgb_extrema_pipe;

    logic        CLK = 1'b0;
    logic        RST_N;
    always #5 CLK = ~CLK;

    logic        in_valid, in_ready, in_sof, out_valid, out_ready, out_sof;
    logic [7:0]  R, G, B, MAX, D;
    logic [17:0] r, g, b, mx, mn, max_min, TOP;
    logic        TOP_NEG, GREY;
    logic [2:0]  RGB_SE;

    logic        p_in_valid, p_in_ready, p_in_sof, p_out_valid, p_out_ready, p_out_sof;
    logic [9:0]  p_R, p_G, p_B, p_MAX, p_D;
    logic [19:0] p_r, p_g, p_b, p_mx, p_mn, p_max_min, p_TOP;
    logic        p_TOP_NEG, p_GREY;
    logic [2:0]  p_RGB_SE;

    rgb_extrema_pipe #(.CW(8), .FW(18)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .R(R), .G(G), .B(B), .r(r), .g(g), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .out_sof(out_sof), .MAX(MAX), .D(D), .max(mx), .min(mn),
        .max_min(max_min), .TOP(TOP), .TOP_NEG(TOP_NEG), .RGB_SE(RGB_SE), .GREY(GREY)
    );

    rgb_extrema_pipe #(.CW(10), .FW(20)) dut_p (
        .CLK(CLK), .RST_N(RST_N), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_sof(p_in_sof), .R(p_R), .G(p_G), .B(p_B), .r(p_r), .g(p_g), .b(p_b),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_sof(p_out_sof),
        .MAX(p_MAX), .D(p_D), .max(p_mx), .min(p_mn), .max_min(p_max_min), .TOP(p_TOP),
        .TOP_NEG(p_TOP_NEG), .RGB_SE(p_RGB_SE), .GREY(p_GREY)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                         input logic sof);
        in_valid = 1'b1;
        in_sof   = sof;
        R = rr; G = gg; B = bb;
        r = {2'b00, rr, 8'h00};
        g = {2'b00, gg, 8'h00};
        b = {2'b00, bb, 8'h00};
    endtask

    // Presents one beat, then checks it is not out after one edge but is after two.
    task automatic send1(input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        drive(rr, gg, bb, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
        tick();
        chk("lat_valid", {63'd0, out_valid}, 64'd1);
    endtask

    function automatic int max3(input int a, input int bb, input int c);
        int m = a;
        if (bb > m) m = bb;
        if (c > m) m = c;
        return m;
    endfunction

    function automatic int min3(input int a, input int bb, input int c);
        int m = a;
        if (bb < m) m = bb;
        if (c < m) m = c;
        return m;
    endfunction

    int         sent, recv, inflight, ex_r, ex_g;
    logic       held_v, held_sof;
    logic [7:0] held_max, held_d;

    initial begin
        RST_N = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        R = '0; G = '0; B = '0; r = '0; g = '0; b = '0;
        p_in_valid = 1'b0; p_in_sof = 1'b0; p_out_ready = 1'b1;
        p_R = '0; p_G = '0; p_B = '0; p_r = '0; p_g = '0; p_b = '0;
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_MAX", {56'd0, MAX}, 64'd0);
        chk("rst_TOP", {46'd0, TOP}, 64'd0);
        chk("rst_RGB_SE", {61'd0, RGB_SE}, 64'd0);
        chk("rst_GREY", {63'd0, GREY}, 64'd0);
        chk("rst_out_sof", {63'd0, out_sof}, 64'd0);
        @(negedge CLK) RST_N = 1'b1;
        tick();
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        send1(8'd200, 8'd100, 8'd50);
        chk("s0_MAX", {56'd0, MAX}, 64'd200);
        chk("s0_D", {56'd0, D}, 64'd150);
        chk("s0_SE", {61'd0, RGB_SE}, 64'd0);
        chk("s0_TOP", {46'd0, TOP}, 64'd12800);
        chk("s0_TOP_NEG", {63'd0, TOP_NEG}, 64'd0);
        chk("s0_max", {46'd0, mx}, 64'd51200);
        chk("s0_min", {46'd0, mn}, 64'd12800);

        send1(8'd100, 8'd200, 8'd50);
        chk("s1_SE", {61'd0, RGB_SE}, 64'd1);
        chk("s1_TOP", {46'd0, TOP}, 64'd12800);
        chk("s1_TOP_NEG", {63'd0, TOP_NEG}, 64'd1);

        send1(8'd10, 8'd200, 8'd100);
        chk("s2_SE", {61'd0, RGB_SE}, 64'd2);
        chk("s2_TOP", {46'd0, TOP}, 64'd23040);
        send1(8'd10, 8'd100, 8'd200);
        chk("s3_SE", {61'd0, RGB_SE}, 64'd3);
        chk("s3_TOP_NEG", {63'd0, TOP_NEG}, 64'd1);
        send1(8'd100, 8'd10, 8'd200);
        chk("s4_SE", {61'd0, RGB_SE}, 64'd4);
        chk("s4_TOP", {46'd0, TOP}, 64'd23040);

        send1(8'd120, 8'd120, 8'd30);
        chk("tieRG_SE", {61'd0, RGB_SE}, 64'd0);
        chk("tieRG_D", {56'd0, D}, 64'd90);
        chk("tieRG_TOP", {46'd0, TOP}, 64'd23040);
        send1(8'd90, 8'd40, 8'd40);
        chk("tieGB_SE", {61'd0, RGB_SE}, 64'd0);
        chk("tieGB_TOP", {46'd0, TOP}, 64'd0);
        send1(8'd77, 8'd77, 8'd77);
        chk("grey_GREY", {63'd0, GREY}, 64'd1);
        chk("grey_D", {56'd0, D}, 64'd0);
        chk("grey_SE", {61'd0, RGB_SE}, 64'd0);
        chk("grey_max_min", {46'd0, max_min}, 64'd0);
        tick();

        // Backpressure with out_ready pattern 1,0,0 and SOF on the third beat.
        sent = 0; recv = 0; inflight = 0; held_v = 1'b0;
        held_max = '0; held_d = '0; held_sof = 1'b0;
        for (int c = 0; c < 80 && recv < 10; c++) begin
            out_ready = (c % 3 == 0);
            if (sent < 10) drive(8'(30 + 20 * sent), 8'(200 - 15 * sent), 8'd100, sent == 2);
            else in_valid = 1'b0;
            #1;
            chk("bp_in_ready", {63'd0, in_ready}, {63'd0, !(inflight == 2 && !out_ready)});
            if (held_v) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_MAX", {56'd0, MAX}, {56'd0, held_max});
                chk("hold_D", {56'd0, D}, {56'd0, held_d});
                chk("hold_sof", {63'd0, out_sof}, {63'd0, held_sof});
            end
            if (out_valid && out_ready) begin
                ex_r = 30 + 20 * recv;
                ex_g = 200 - 15 * recv;
                chk("bp_MAX", {56'd0, MAX}, 64'(max3(ex_r, ex_g, 100)));
                chk("bp_D", {56'd0, D}, 64'(max3(ex_r, ex_g, 100) - min3(ex_r, ex_g, 100)));
                chk("bp_sof", {63'd0, out_sof}, {63'd0, recv == 2});
                recv++;
                inflight--;
            end
            held_v   = out_valid && !out_ready;
            held_max = MAX;
            held_d   = D;
            held_sof = out_sof;
            if (in_valid && in_ready) begin
                sent++;
                inflight++;
            end
            tick();
        end
        chk("bp_count", 64'(recv), 64'd10);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        chk("bp_no_extra", {63'd0, out_valid}, 64'd0);

        // Reset with two beats in flight.
        drive(8'd11, 8'd22, 8'd33, 1'b0);
        tick();
        drive(8'd44, 8'd55, 8'd66, 1'b0);
        tick();
        in_valid = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_MAX", {56'd0, MAX}, 64'd0);
        @(negedge CLK) RST_N = 1'b1;
        tick();
        send1(8'd200, 8'd100, 8'd50);
        chk("post_rst_MAX", {56'd0, MAX}, 64'd200);
        chk("post_rst_D", {56'd0, D}, 64'd150);
        tick();

        // Wider instance.
        p_in_valid = 1'b1;
        p_R = 10'd1023; p_G = 10'd0; p_B = 10'd512;
        p_r = {10'd1023, 10'd0}; p_g = 20'd0; p_b = {10'd512, 10'd0};
        tick();
        p_in_valid = 1'b0;
        tick();
        chk("p_valid", {63'd0, p_out_valid}, 64'd1);
        chk("p_MAX", {54'd0, p_MAX}, 64'd1023);
        chk("p_D", {54'd0, p_D}, 64'd1023);
        chk("p_SE", {61'd0, p_RGB_SE}, 64'd5);
        chk("p_TOP", {44'd0, p_TOP}, 64'd524288);
        chk("p_TOP_NEG", {63'd0, p_TOP_NEG}, 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
